// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write controller: FSM states, field
// positions inside the LSU LCD register, and the slow-command decode.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    localparam int ON_BIT   = 31;
    localparam int BL_BIT   = 30;
    localparam int CLR_BIT  = 11;
    localparam int GO_BIT   = 10;
    localparam int RS_BIT   = 9;
    localparam int DATA_MSB = 7;

    // Clear display and return home both take the long execution time.
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    function automatic logic is_clr_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used for every LCD timing interval; it parks at zero
// and the zero flag tells the FSM the current interval has elapsed.
module lcd_delay_cnt #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lsu_lcd_ctrl.sv
// Turns LSU LCD register writes into HD44780 write cycles with setup, enable
// pulse, hold and per-command execution delay; reports busy/done/overrun.
module lsu_lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS_CYC   = 4,
    parameter int unsigned T_EN_CYC   = 12,
    parameter int unsigned T_AH_CYC   = 4,
    parameter int unsigned T_EXEC_CYC = 2500,
    parameter int unsigned T_CLR_CYC  = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_i,
    output logic        lcd_on,
    output logic        lcd_blon,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_data,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovr_o
);

    localparam int CNT_W = $clog2(T_CLR_CYC) + 1;
    localparam logic [CNT_W-1:0] AS_LOAD   = CNT_W'(T_AS_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LOAD   = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] AH_LOAD   = CNT_W'(T_AH_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(T_CLR_CYC - 1);

    lcd_state_e       state;
    logic             go_q;
    logic             start;
    logic             is_clr;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             unused_bits;

    assign unused_bits = ^{lcd_i[29:12], lcd_i[8]};
    assign lcd_rw      = 1'b0;
    assign start       = lcd_i[GO_BIT] && !go_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            go_q     <= 1'b0;
            lcd_on   <= 1'b0;
            lcd_blon <= 1'b0;
        end else begin
            go_q     <= lcd_i[GO_BIT];
            lcd_on   <= lcd_i[ON_BIT];
            lcd_blon <= lcd_i[BL_BIT];
        end
    end

    // Every load is issued when the counter has reached zero (or is idle at zero).
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE:  if (start)    begin cnt_load = 1'b1; cnt_val = AS_LOAD; end
            SETUP: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = EN_LOAD; end
            PULSE: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = AH_LOAD; end
            HOLD:  if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_val  = is_clr ? CLR_LOAD : EXEC_LOAD;
            end
            default: ;
        endcase
    end

    lcd_delay_cnt #(.W(CNT_W)) u_delay_cnt (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            lcd_en   <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            ovr_o    <= 1'b0;
            is_clr   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            // A dropped start outranks a simultaneous software clear.
            if (start && state != IDLE) begin
                ovr_o <= 1'b1;
            end else if (lcd_i[CLR_BIT]) begin
                ovr_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        lcd_rs   <= lcd_i[RS_BIT];
                        lcd_data <= lcd_i[DATA_MSB:0];
                        is_clr   <= is_clr_cmd(lcd_i[RS_BIT], lcd_i[DATA_MSB:0]);
                        busy_o   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        lcd_en <= 1'b1;
                        state  <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        lcd_en <= 1'b0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
